// File: rtl/filt_pkg.sv
// Shared constants and helpers for the multi-channel debounce filter.
// Holds default channel count, run thresholds and the counter width function.
package filt_pkg;

  localparam int FILT_CH_DEF  = 4;
  localparam int FILT_ON_DEF  = 3;
  localparam int FILT_OFF_DEF = 3;

  localparam int FILT_CH_MAX  = 32;
  localparam int FILT_THR_MAX = 255;

  // Bits needed to hold 0..max(on,off); a single-tick threshold
  // still gets one bit so the counter never degenerates to zero width.
  function automatic int filt_cnt_w(input int on, input int off);
    int m;
    m = (on > off) ? on : off;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/filt_chan.sv
// One debounce channel: run counter, filtered level, optional edge pulses.
// Ports: clk, rst (async, active-high), tick, i -> y [, rise, fall with FILT_MULTI_EDGE_EN].
import filt_pkg::*;

module filt_chan #(
  parameter int ON_CNT  = FILT_ON_DEF,
  parameter int OFF_CNT = FILT_OFF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic i,
  output logic y
`ifdef FILT_MULTI_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int CW = filt_cnt_w(ON_CNT, OFF_CNT);
  localparam logic [CW-1:0] ON_M1  = CW'(ON_CNT - 1);
  localparam logic [CW-1:0] OFF_M1 = CW'(OFF_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          y_q, y_d;
  logic [CW-1:0] thr_m1;

  // Threshold depends on the direction of the pending change.
  assign thr_m1 = y_q ? OFF_M1 : ON_M1;

  always_comb begin
    cnt_d = cnt_q;
    y_d   = y_q;
    if (tick) begin
      if (i == y_q) begin
        cnt_d = '0;
      end else if (cnt_q >= thr_m1) begin
        y_d   = i;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      y_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;

`ifdef FILT_MULTI_EDGE_EN
  logic rise_q, fall_q;

  // Registered with the level update so the pulse lines up with y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= y_d & ~y_q;
      fall_q <= ~y_d & y_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: rtl/filt_multi.sv
// Multi-channel tick-sampled debounce filter; CH independent filt_chan slices.
// Ports: clk, rst, tick, i[CH], y[CH] [, rise/fall[CH] when FILT_MULTI_EDGE_EN is defined].
import filt_pkg::*;

module filt_multi #(
  parameter int CH      = FILT_CH_DEF,
  parameter int ON_CNT  = FILT_ON_DEF,
  parameter int OFF_CNT = FILT_OFF_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [CH-1:0] i,
  output logic [CH-1:0] y
`ifdef FILT_MULTI_EDGE_EN
  ,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
`endif
);

  if (CH < 1 || CH > FILT_CH_MAX) begin : g_bad_ch
    $fatal(1, "filt_multi: CH out of range 1..32");
  end
  if (ON_CNT < 1 || ON_CNT > FILT_THR_MAX) begin : g_bad_on
    $fatal(1, "filt_multi: ON_CNT out of range 1..255");
  end
  if (OFF_CNT < 1 || OFF_CNT > FILT_THR_MAX) begin : g_bad_off
    $fatal(1, "filt_multi: OFF_CNT out of range 1..255");
  end

  for (genvar n = 0; n < CH; n++) begin : g_ch
    filt_chan #(
      .ON_CNT (ON_CNT),
      .OFF_CNT(OFF_CNT)
    ) u_chan (
      .clk (clk),
      .rst (rst),
      .tick(tick),
      .i   (i[n]),
      .y   (y[n])
`ifdef FILT_MULTI_EDGE_EN
      ,
      .rise(rise[n]),
      .fall(fall[n])
`endif
    );
  end

endmodule

// File: tb/tb_filt_multi.sv
// Self-checking bench for filt_multi: two instances (3/3 and 1/5 thresholds),
// table vectors, hand sequences for tick gating and reset, random scoreboard run.
module tb_filt_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] ia;
  logic [3:0] ya;
  logic [1:0] ib;
  logic [1:0] yb;
`ifdef FILT_MULTI_EDGE_EN
  logic [3:0] ra, fa;
  logic [1:0] rb, fb;
`endif

  always #5 clk = ~clk;

  filt_multi #(.CH(4), .ON_CNT(3), .OFF_CNT(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .tick(tick),
    .i   (ia),
    .y   (ya)
`ifdef FILT_MULTI_EDGE_EN
    ,
    .rise(ra),
    .fall(fa)
`endif
  );

  filt_multi #(.CH(2), .ON_CNT(1), .OFF_CNT(5)) dut_b (
    .clk (clk),
    .rst (rst),
    .tick(tick),
    .i   (ib),
    .y   (yb)
`ifdef FILT_MULTI_EDGE_EN
    ,
    .rise(rb),
    .fall(fb)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain run-length counters per channel.
  int         run_a[4];
  int         run_b[2];
  logic [3:0] my_a;
  logic [1:0] my_b;

  typedef struct {
    logic [3:0] ya, ra, fa;
    logic [1:0] yb, rb, fb;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] ia;
    logic [1:0] ib;
    logic [3:0] ya;
    logic [1:0] yb;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) run_a[n] = 0;
    for (int n = 0; n < 2; n++) run_b[n] = 0;
    my_a = '0;
    my_b = '0;
  endtask

  task automatic model_edge(input logic t, input logic [3:0] a,
                            input logic [1:0] b);
    if (t) begin
      for (int n = 0; n < 4; n++) begin
        if (a[n] == my_a[n]) run_a[n] = 0;
        else begin
          run_a[n]++;
          if (run_a[n] == (my_a[n] ? 3 : 3)) begin
            my_a[n] = a[n];
            run_a[n] = 0;
          end
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (b[n] == my_b[n]) run_b[n] = 0;
        else begin
          run_b[n]++;
          if (run_b[n] == (my_b[n] ? 5 : 1)) begin
            my_b[n] = b[n];
            run_b[n] = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic t, input logic [3:0] a,
                      input logic [1:0] b);
    exp_t e;
    logic [3:0] pa;
    logic [1:0] pb;
    tick = t;
    ia   = a;
    ib   = b;
    pa   = my_a;
    pb   = my_b;
    model_edge(t, a, b);
    e.ya = my_a;
    e.ra = my_a & ~pa;
    e.fa = ~my_a & pa;
    e.yb = my_b;
    e.rb = my_b & ~pb;
    e.fb = ~my_b & pb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_ya", {4'h0, ya}, {4'h0, e.ya});
    chk("sb_yb", {6'h0, yb}, {6'h0, e.yb});
`ifdef FILT_MULTI_EDGE_EN
    chk("sb_ra", {4'h0, ra}, {4'h0, e.ra});
    chk("sb_fa", {4'h0, fa}, {4'h0, e.fa});
    chk("sb_rb", {6'h0, rb}, {6'h0, e.rb});
    chk("sb_fb", {6'h0, fb}, {6'h0, e.fb});
`endif
  endtask

  vec_t tv[6];

  initial begin
    logic [3:0] ra_v;
    logic [1:0] rb_v;
    logic       tk;

    tv[0] = '{4'b0011, 2'b01, 4'b0000, 2'b01};
    tv[1] = '{4'b0011, 2'b10, 4'b0000, 2'b11};
    tv[2] = '{4'b0001, 2'b00, 4'b0001, 2'b11};
    tv[3] = '{4'b0011, 2'b00, 4'b0001, 2'b11};
    tv[4] = '{4'b0011, 2'b10, 4'b0001, 2'b11};
    tv[5] = '{4'b0011, 2'b10, 4'b0011, 2'b10};

    rst  = 1'b0;
    tick = 1'b0;
    ia   = '0;
    ib   = '0;
    model_reset();
    #1 rst = 1'b1;

    // Reset holds everything low even with tick and all-ones input.
    tick = 1'b1;
    ia   = 4'hF;
    ib   = 2'b11;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_ya", {4'h0, ya}, 8'h00);
      chk("rst_yb", {6'h0, yb}, 8'h00);
`ifdef FILT_MULTI_EDGE_EN
      chk("rst_ra", {4'h0, ra}, 8'h00);
      chk("rst_fa", {4'h0, fa}, 8'h00);
`endif
    end
    ia = '0;
    ib = '0;
    rst = 1'b0;
    model_reset();

    // Table: ch0 3-tick rise, ch1 glitch restart, dut_b 1-tick on / 5-tick off.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, tv[k].ia, tv[k].ib);
      chk($sformatf("tv%0d_ya", k), {4'h0, ya}, {4'h0, tv[k].ya});
      chk($sformatf("tv%0d_yb", k), {6'h0, yb}, {6'h0, tv[k].yb});
    end

    // Tick every 4th clk; ch2/ch3 toggle on non-tick edges only.
    for (int e = 1; e <= 12; e++) begin
      tk = (e % 4 == 0);
      step(tk, tk ? 4'b0111 : 4'b1011, 2'b10);
      if (e == 11) chk("tick11_ya", {4'h0, ya}, 8'h03);
      if (e == 12) chk("tick12_ya", {4'h0, ya}, 8'h07);
    end

    // Two of three zeros on ch0, then async reset mid-cycle.
    step(1'b1, 4'b0110, 2'b10);
    step(1'b1, 4'b0110, 2'b10);
    chk("pre_rst_ya", {4'h0, ya}, 8'h07);
    #2 rst = 1'b1;
    #1;
    chk("async_ya", {4'h0, ya}, 8'h00);
    chk("async_yb", {6'h0, yb}, 8'h00);
    model_reset();
    #1 rst = 1'b0;
    step(1'b1, 4'b0001, 2'b00);
    step(1'b1, 4'b0001, 2'b00);
    chk("post_rst2_ya", {4'h0, ya}, 8'h00);
    step(1'b1, 4'b0001, 2'b00);
    chk("post_rst3_ya", {4'h0, ya}, 8'h01);

    // Random runs per channel, random tick; scoreboard compares every edge.
    ra_v = 4'b0001;
    rb_v = 2'b00;
    for (int k = 0; k < 400; k++) begin
      for (int n = 0; n < 4; n++)
        if ($urandom_range(0, 3) == 0) ra_v[n] = ~ra_v[n];
      for (int n = 0; n < 2; n++)
        if ($urandom_range(0, 4) == 0) rb_v[n] = ~rb_v[n];
      step($urandom_range(0, 3) != 0, ra_v, rb_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filt_multi.md
FILT_MULTI -- requirements
Module: filt_multi

Interface
REQ-001 The block SHALL have parameter CH, default 4, meaning the number of independent filter channels (legal range 1..32).
REQ-002 The block SHALL have parameter ON_CNT, default 3, meaning the number of consecutive sampled 1s needed to assert y (legal range 1..255).
REQ-003 The block SHALL have parameter OFF_CNT, default 3, meaning the number of consecutive sampled 0s needed to deassert y (legal range 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit, the clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-006 The block SHALL have port tick, input, 1 bit, the sample strobe; a channel samples i only on edges where tick=1.
REQ-007 The block SHALL have port i, input, CH bits, the raw channel inputs, already synchronous to clk.
REQ-008 The block SHALL have port y, output, CH bits, the filtered levels, each driven from a register.
REQ-009 The block SHALL have ports rise and fall, outputs, CH bits each, giving one-cycle edge pulses of y; these ports exist only under FILT_MULTI_EDGE_EN.

Function
REQ-010 Each channel SHALL hold a run counter of width clog2(max(ON_CNT,OFF_CNT)+1) and its y register, and SHALL be fully independent of the other channels.
REQ-011 On a tick edge where i[n]==y[n], channel n SHALL clear its counter to 0.
REQ-012 On a tick edge where i[n]!=y[n], channel n SHALL increment its counter when counter < THR-1, where THR=ON_CNT if y[n]=0 and THR=OFF_CNT if y[n]=1.
REQ-013 On a tick edge where i[n]!=y[n] and counter==THR-1, channel n SHALL set y[n]<=i[n] and clear the counter.
REQ-014 Latency: y[n] SHALL change on the THR-th consecutive qualifying tick edge and be visible immediately after that edge.
REQ-015 Any sample equal to y[n] within a run SHALL restart the count (glitch rejection); runs SHALL NOT accumulate across interruptions.
REQ-016 On an edge where tick=0, counters and y SHALL hold; samples on non-tick edges SHALL be ignored and SHALL NOT break a run.
REQ-017 With ON_CNT=1 or OFF_CNT=1, the corresponding transition SHALL occur on the first differing tick edge.
REQ-018 The counter SHALL never exceed THR-1 and SHALL never wrap.
REQ-019 rise[n] SHALL pulse high for exactly one clk cycle, registered together with the y[n] 0->1 update; fall[n] SHALL do the same for the 1->0 update; rise[n] and fall[n] SHALL never be high together.

Reset
REQ-020 While rst=1, all counters SHALL be 0, y SHALL be all 0, and rise/fall SHALL be all 0.
REQ-021 Reset asserted mid-run SHALL discard partial counts, and the first run after release SHALL start from 0.
REQ-022 Channels SHALL begin filtering on the first tick edge after rst deasserts.

Configuration
REQ-023 With macro FILT_MULTI_EDGE_EN defined, the rise/fall ports and their registers SHALL be present and behave per REQ-019.
REQ-024 Without FILT_MULTI_EDGE_EN, the rise/fall ports and their logic SHALL be absent, and y behaviour SHALL be identical to the configured build.

Structure
REQ-025 Shared package filt_pkg SHALL hold the default constants FILT_CH_DEF=4, FILT_ON_DEF=3, FILT_OFF_DEF=3 and a function for the counter width.
REQ-026 One sub-module, filt_chan (one channel: counter, y, optional edge register), SHALL be instantiated CH times by a generate loop.
REQ-027 Parameter checks SHALL be elaboration-time: an out-of-range CH, ON_CNT or OFF_CNT SHALL be a fatal error.

Verification
REQ-028 With defaults and tick=1, i[0]=1 for 3 edges SHALL give y[0]=1 after the 3rd edge, with rise[0] high for one cycle.
REQ-029 With defaults, i[1] pattern 1,1,0,1,1 SHALL keep y[1]=0; a following 1 SHALL set y[1]=1 after that 3rd consecutive 1.
REQ-030 With tick high every 4th clk and ON_CNT=3, i[2]=1 held SHALL set y[2] on the 3rd tick edge (clk edge 12), and i toggling on non-tick edges SHALL have no effect.
REQ-031 With ON_CNT=1 and OFF_CNT=5, y SHALL follow a 1 in one tick, and a 0 SHALL require 5 ticks, giving a fall pulse on the 5th.
REQ-032 With y=1, asserting rst after 2 of 3 zeros SHALL clear y to 0 immediately (async), and after release 3 ones SHALL be needed to reassert y.
REQ-033 With CH=4, driving all channels with distinct patterns SHALL make each y[n] match its scalar reference model, with no cross-channel interaction.
